// File: rtl/bp_me_hb_link_bridge.sv
// BedRock memory-forward to 32-bit HammerBlade link bridge.
// One transaction in flight; 64-bit accesses become two link words.
module bp_me_hb_link_bridge #(
  parameter int paddr_width_p     = 40,
  parameter int did_width_p       = 19,
  parameter int link_data_width_p = 32,
  parameter int fill_width_p      = 64
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic                         fwd_v_i,
  output logic                         fwd_ready_and_o,
  input  logic                         fwd_store_i,
  input  logic [paddr_width_p-1:0]     fwd_addr_i,
  input  logic [1:0]                   fwd_size_i,
  input  logic [fill_width_p-1:0]      fwd_data_i,
  input  logic [did_width_p-1:0]       fwd_payload_i,

  output logic                         out_v_o,
  input  logic                         out_ready_i,
  output logic                         out_we_o,
  output logic [paddr_width_p-1:0]     out_addr_o,
  output logic [link_data_width_p-1:0] out_data_o,
  output logic [3:0]                   out_mask_o,
  output logic                         out_tag_o,

  input  logic                         ret_v_i,
  input  logic [link_data_width_p-1:0] ret_data_i,
  input  logic                         ret_tag_i,

  output logic                         rev_v_o,
  input  logic                         rev_ready_and_i,
  output logic                         rev_store_o,
  output logic [paddr_width_p-1:0]     rev_addr_o,
  output logic [1:0]                   rev_size_o,
  output logic [fill_width_p-1:0]      rev_data_o,
  output logic [did_width_p-1:0]       rev_payload_o
);

  localparam int lw = link_data_width_p;

  typedef enum logic [2:0] {
    e_ready,
    e_send_lo,
    e_send_hi,
    e_wait,
    e_reply
  } state_e;

  state_e state_r, state_n;

  logic                     store_r;
  logic [paddr_width_p-1:0] addr_r;
  logic [1:0]               size_r;
  logic [fill_width_p-1:0]  data_r;
  logic [did_width_p-1:0]   payload_r;
  logic [lw-1:0]            lo_r, hi_r;
  logic                     lo_done_r, hi_done_r;

  logic [paddr_width_p-1:0] addr_align;
  logic                     fwd_accept;
  logic                     out_fire, rev_fire;
  logic                     ret_ok, ret_lo, ret_hi;
  logic                     lo_n, hi_n, all_done;
  logic                     narrow_hi;
  logic [lw-1:0]            narrow_word;

  always_comb begin
    addr_align = fwd_addr_i;
    case (fwd_size_i)
      2'd1:    addr_align[0]   = 1'b0;
      2'd2:    addr_align[1:0] = 2'b00;
      2'd3:    addr_align[2:0] = 3'b000;
      default: addr_align      = fwd_addr_i;
    endcase
  end

  assign fwd_accept = (state_r == e_ready) & fwd_v_i;
  assign out_fire   = out_v_o & out_ready_i;
  assign rev_fire   = rev_v_o & rev_ready_and_i;

  // A return may land in the same cycle its request handshakes.
  assign ret_ok = ret_v_i
                & ((state_r == e_send_hi)
                 | (state_r == e_wait)
                 | out_fire);
  assign ret_lo = ret_ok & ~ret_tag_i;
  assign ret_hi = ret_ok &  ret_tag_i;

  assign lo_n      = lo_done_r | ret_lo;
  assign hi_n      = hi_done_r | ret_hi;
  assign narrow_hi = addr_r[2];
  assign all_done  = (size_r == 2'd3)
                   ? (lo_n & hi_n)
                   : (narrow_hi ? hi_n : lo_n);

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready:
        if (fwd_v_i)
          state_n = ((fwd_size_i != 2'd3) && addr_align[2])
                  ? e_send_hi : e_send_lo;
      e_send_lo:
        if (out_fire)
          state_n = (size_r == 2'd3) ? e_send_hi : e_wait;
      e_send_hi:
        if (out_fire) state_n = e_wait;
      e_wait:
        if (all_done) state_n = e_reply;
      e_reply:
        if (rev_ready_and_i) state_n = e_ready;
      default:
        state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_ready;
      store_r   <= 1'b0;
      addr_r    <= '0;
      size_r    <= '0;
      data_r    <= '0;
      payload_r <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
      lo_done_r <= 1'b0;
      hi_done_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (fwd_accept) begin
        store_r   <= fwd_store_i;
        addr_r    <= addr_align;
        size_r    <= fwd_size_i;
        data_r    <= fwd_data_i;
        payload_r <= fwd_payload_i;
      end
      if (ret_lo) begin
        lo_r      <= ret_data_i;
        lo_done_r <= 1'b1;
      end
      if (ret_hi) begin
        hi_r      <= ret_data_i;
        hi_done_r <= 1'b1;
      end
      if (rev_fire) begin
        lo_done_r <= 1'b0;
        hi_done_r <= 1'b0;
      end
    end
  end

  assign fwd_ready_and_o = (state_r == e_ready);

  // Request fields come straight from captured state, so they
  // cannot move while the link stalls.
  assign out_v_o    = (state_r == e_send_lo) | (state_r == e_send_hi);
  assign out_tag_o  = (state_r == e_send_hi);
  assign out_we_o   = store_r;
  assign out_addr_o = {addr_r[paddr_width_p-1:3], out_tag_o, 2'b00};
  assign out_data_o = out_tag_o
                    ? data_r[2*lw-1:lw]
                    : data_r[lw-1:0];

  always_comb begin
    out_mask_o = 4'b1111;
    case (size_r)
      2'd1:    out_mask_o = 4'b0011 << addr_r[1:0];
      2'd0:    out_mask_o = 4'b0001 << addr_r[1:0];
      default: out_mask_o = 4'b1111;
    endcase
  end

  assign narrow_word   = narrow_hi ? hi_r : lo_r;
  assign rev_v_o       = (state_r == e_reply);
  assign rev_store_o   = store_r;
  assign rev_addr_o    = addr_r;
  assign rev_size_o    = size_r;
  assign rev_payload_o = payload_r;
  assign rev_data_o    = store_r ? '0
                       : (size_r == 2'd3) ? {hi_r, lo_r}
                       : {narrow_word, narrow_word};

  always @(posedge clk_i) begin
    if (!reset_i)
      assert (!(ret_v_i && ((state_r == e_ready)
                         || (state_r == e_reply))))
      else $warning("link return dropped: no request outstanding");
  end

endmodule

// File: tb/tb_bp_me_hb_link_bridge.sv
// Directed bench for bp_me_hb_link_bridge.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bp_me_hb_link_bridge;

  localparam int PW = 40;
  localparam int DW = 19;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          fwd_v_i;
  logic          fwd_ready_and_o;
  logic          fwd_store_i;
  logic [PW-1:0] fwd_addr_i;
  logic [1:0]    fwd_size_i;
  logic [63:0]   fwd_data_i;
  logic [DW-1:0] fwd_payload_i;
  logic          out_v_o;
  logic          out_ready_i;
  logic          out_we_o;
  logic [PW-1:0] out_addr_o;
  logic [31:0]   out_data_o;
  logic [3:0]    out_mask_o;
  logic          out_tag_o;
  logic          ret_v_i;
  logic [31:0]   ret_data_i;
  logic          ret_tag_i;
  logic          rev_v_o;
  logic          rev_ready_and_i;
  logic          rev_store_o;
  logic [PW-1:0] rev_addr_o;
  logic [1:0]    rev_size_o;
  logic [63:0]   rev_data_o;
  logic [DW-1:0] rev_payload_o;

  int tests = 0;
  int fails = 0;

  bp_me_hb_link_bridge dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .fwd_v_i        (fwd_v_i),
    .fwd_ready_and_o(fwd_ready_and_o),
    .fwd_store_i    (fwd_store_i),
    .fwd_addr_i     (fwd_addr_i),
    .fwd_size_i     (fwd_size_i),
    .fwd_data_i     (fwd_data_i),
    .fwd_payload_i  (fwd_payload_i),
    .out_v_o        (out_v_o),
    .out_ready_i    (out_ready_i),
    .out_we_o       (out_we_o),
    .out_addr_o     (out_addr_o),
    .out_data_o     (out_data_o),
    .out_mask_o     (out_mask_o),
    .out_tag_o      (out_tag_o),
    .ret_v_i        (ret_v_i),
    .ret_data_i     (ret_data_i),
    .ret_tag_i      (ret_tag_i),
    .rev_v_o        (rev_v_o),
    .rev_ready_and_i(rev_ready_and_i),
    .rev_store_o    (rev_store_o),
    .rev_addr_o     (rev_addr_o),
    .rev_size_o     (rev_size_o),
    .rev_data_o     (rev_data_o),
    .rev_payload_o  (rev_payload_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic st, input logic [PW-1:0] a,
                      input logic [1:0] sz, input logic [63:0] d,
                      input logic [DW-1:0] p);
    fwd_v_i       = 1'b1;
    fwd_store_i   = st;
    fwd_addr_i    = a;
    fwd_size_i    = sz;
    fwd_data_i    = d;
    fwd_payload_i = p;
  endtask

  task automatic ret(input logic t, input logic [31:0] d);
    ret_v_i    = 1'b1;
    ret_tag_i  = t;
    ret_data_i = d;
  endtask

  initial begin
    reset_i         = 1'b1;
    fwd_v_i         = 1'b0;
    fwd_store_i     = 1'b0;
    fwd_addr_i      = '0;
    fwd_size_i      = '0;
    fwd_data_i      = '0;
    fwd_payload_i   = '0;
    out_ready_i     = 1'b1;
    ret_v_i         = 1'b0;
    ret_data_i      = '0;
    ret_tag_i       = 1'b0;
    rev_ready_and_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_fwd_ready", 64'(fwd_ready_and_o), 64'd1);
    chk("rst_out_v", 64'(out_v_o), 64'd0);
    chk("rst_rev_v", 64'(rev_v_o), 64'd0);

    // 64-bit load, lo returns first
    send(1'b0, 40'h80_0000_0010, 2'd3, 64'h0, 19'h1_2345);
    tick();
    fwd_v_i = 1'b0;
    chk("ld_lo_v", 64'(out_v_o), 64'd1);
    chk("ld_lo_addr", 64'(out_addr_o), 64'h80_0000_0010);
    chk("ld_lo_tag", 64'(out_tag_o), 64'd0);
    chk("ld_lo_mask", 64'(out_mask_o), 64'hF);
    chk("ld_lo_we", 64'(out_we_o), 64'd0);
    chk("ld_busy", 64'(fwd_ready_and_o), 64'd0);
    tick();
    chk("ld_hi_addr", 64'(out_addr_o), 64'h80_0000_0014);
    chk("ld_hi_tag", 64'(out_tag_o), 64'd1);
    ret(1'b0, 32'h1111_2222);
    tick();
    ret(1'b1, 32'h3333_4444);
    chk("ld_no_dup", 64'(out_v_o), 64'd0);
    chk("ld_rev_early", 64'(rev_v_o), 64'd0);
    tick();
    ret_v_i = 1'b0;
    chk("ld_rev_v", 64'(rev_v_o), 64'd1);
    chk("ld_rev_data", rev_data_o, 64'h3333_4444_1111_2222);
    chk("ld_rev_pay", 64'(rev_payload_o), 64'h1_2345);
    chk("ld_rev_addr", 64'(rev_addr_o), 64'h80_0000_0010);
    chk("ld_rev_size", 64'(rev_size_o), 64'd3);
    tick();
    chk("ld_done", 64'(fwd_ready_and_o), 64'd1);

    // same load, hi returns first and late
    send(1'b0, 40'h80_0000_0010, 2'd3, 64'h0, 19'h0_0042);
    tick();
    fwd_v_i = 1'b0;
    tick();
    tick();
    ret(1'b1, 32'h3333_4444);
    tick();
    ret_v_i = 1'b0;
    chk("ooo_after_first", 64'(rev_v_o), 64'd0);
    ret(1'b0, 32'h1111_2222);
    tick();
    ret_v_i = 1'b0;
    chk("ooo_rev_v", 64'(rev_v_o), 64'd1);
    chk("ooo_rev_data", rev_data_o, 64'h3333_4444_1111_2222);
    tick();

    // byte store in the high word, zero-latency return
    send(1'b1, 40'h80_0000_0006, 2'd0, 64'hABAB_ABAB_ABAB_ABAB, 19'h7);
    tick();
    fwd_v_i = 1'b0;
    chk("st0_v", 64'(out_v_o), 64'd1);
    chk("st0_addr", 64'(out_addr_o), 64'h80_0000_0004);
    chk("st0_tag", 64'(out_tag_o), 64'd1);
    chk("st0_mask", 64'(out_mask_o), 64'h4);
    chk("st0_we", 64'(out_we_o), 64'd1);
    chk("st0_data", 64'(out_data_o), 64'hABAB_ABAB);
    ret(1'b1, 32'hFFFF_FFFF);
    tick();
    ret_v_i = 1'b0;
    chk("st0_no_dup", 64'(out_v_o), 64'd0);
    chk("st0_rev_early", 64'(rev_v_o), 64'd0);
    tick();
    chk("st0_rev_v", 64'(rev_v_o), 64'd1);
    chk("st0_rev_data", rev_data_o, 64'd0);
    chk("st0_rev_store", 64'(rev_store_o), 64'd1);
    tick();

    // 64-bit store with link backpressure
    out_ready_i = 1'b0;
    send(1'b1, 40'h80_0000_0020, 2'd3, 64'h5566_7788_1122_3344, 19'h3);
    tick();
    fwd_v_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_v", 64'(out_v_o), 64'd1);
      chk("bp_addr", 64'(out_addr_o), 64'h80_0000_0020);
      chk("bp_data", 64'(out_data_o), 64'h1122_3344);
      chk("bp_tag", 64'(out_tag_o), 64'd0);
      chk("bp_busy", 64'(fwd_ready_and_o), 64'd0);
      tick();
    end
    out_ready_i = 1'b1;
    chk("bp_lo_still", 64'(out_addr_o), 64'h80_0000_0020);
    tick();
    chk("bp_hi_addr", 64'(out_addr_o), 64'h80_0000_0024);
    chk("bp_hi_data", 64'(out_data_o), 64'h5566_7788);
    chk("bp_hi_mask", 64'(out_mask_o), 64'hF);
    ret(1'b0, 32'h0);
    tick();
    chk("bp_no_dup", 64'(out_v_o), 64'd0);
    ret(1'b1, 32'h0);
    tick();
    ret_v_i = 1'b0;
    chk("bp_rev_v", 64'(rev_v_o), 64'd1);
    chk("bp_rev_data", rev_data_o, 64'd0);

    // reverse backpressure; a waiting fwd is held off
    rev_ready_and_i = 1'b0;
    send(1'b0, 40'h80_0000_0030, 2'd2, 64'h0, 19'h5_5555);
    for (int i = 0; i < 3; i++) begin
      chk("rbp_v", 64'(rev_v_o), 64'd1);
      chk("rbp_addr", 64'(rev_addr_o), 64'h80_0000_0020);
      chk("rbp_pay", 64'(rev_payload_o), 64'h3);
      chk("rbp_busy", 64'(fwd_ready_and_o), 64'd0);
      tick();
    end
    rev_ready_and_i = 1'b1;
    chk("rbp_hs_busy", 64'(fwd_ready_and_o), 64'd0);
    tick();
    chk("rbp_rev_clr", 64'(rev_v_o), 64'd0);
    chk("rbp_ready", 64'(fwd_ready_and_o), 64'd1);
    chk("rbp_no_req", 64'(out_v_o), 64'd0);
    tick();
    fwd_v_i = 1'b0;
    chk("w_v", 64'(out_v_o), 64'd1);
    chk("w_addr", 64'(out_addr_o), 64'h80_0000_0030);
    chk("w_tag", 64'(out_tag_o), 64'd0);
    chk("w_mask", 64'(out_mask_o), 64'hF);
    ret(1'b0, 32'hDEAD_BEEF);
    tick();
    ret_v_i = 1'b0;
    tick();
    chk("w_rev_v", 64'(rev_v_o), 64'd1);
    chk("w_rev_data", rev_data_o, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("w_rev_pay", 64'(rev_payload_o), 64'h5_5555);
    tick();

    // halfword load, then reset while waiting
    send(1'b0, 40'h80_0000_0042, 2'd1, 64'h0, 19'h1);
    tick();
    fwd_v_i = 1'b0;
    chk("h_addr", 64'(out_addr_o), 64'h80_0000_0040);
    chk("h_mask", 64'(out_mask_o), 64'hC);
    chk("h_tag", 64'(out_tag_o), 64'd0);
    tick();
    chk("h_wait", 64'(out_v_o), 64'd0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("mr_out_v", 64'(out_v_o), 64'd0);
    chk("mr_rev_v", 64'(rev_v_o), 64'd0);
    chk("mr_ready", 64'(fwd_ready_and_o), 64'd1);
    ret(1'b0, 32'h9999_9999);
    tick();
    ret_v_i = 1'b0;
    chk("late_rev_v", 64'(rev_v_o), 64'd0);
    chk("late_ready", 64'(fwd_ready_and_o), 64'd1);
    chk("late_out_v", 64'(out_v_o), 64'd0);

    // fresh 64-bit load after reset needs both halves
    send(1'b0, 40'h80_0000_0100, 2'd3, 64'h0, 19'h2);
    tick();
    fwd_v_i = 1'b0;
    tick();
    tick();
    ret(1'b1, 32'hCAFE_0001);
    tick();
    ret_v_i = 1'b0;
    tick();
    chk("pr_one_half", 64'(rev_v_o), 64'd0);
    ret(1'b0, 32'hCAFE_0000);
    tick();
    ret_v_i = 1'b0;
    chk("pr_rev_v", 64'(rev_v_o), 64'd1);
    chk("pr_rev_data", rev_data_o, 64'hCAFE_0001_CAFE_0000);
    tick();
    chk("pr_idle", 64'(fwd_ready_and_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_me_hb_link_bridge.md
Name: bp_me_hb_link_bridge

Overview:
- Downstream of the unicore HammerBlade/miniblade configuration: converts BedRock memory-forward messages (64-bit fill/block, 19-bit mem_noc_did payload) from the BlackParrot unicore into 32-bit HammerBlade link requests.
- Reassembles the link returns into BedRock memory-reverse messages.
- Keeps one BedRock transaction outstanding; 64-bit accesses split into two link words.

Parameters:
- paddr_width_p, 40, physical address width
- did_width_p, 19, width of opaque payload returned unchanged with the reverse message
- link_data_width_p, 32, link word width; fixed at 32, other values unsupported
- fill_width_p, 64, BedRock data width; fixed at 2*link_data_width_p

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- fwd_v_i  in  1  forward message valid
- fwd_ready_and_o  out  1  forward ready (ready-and handshake)
- fwd_store_i  in  1  1=store, 0=load
- fwd_addr_i  in  paddr_width_p  byte address
- fwd_size_i  in  2  log2 bytes (0..3)
- fwd_data_i  in  64  store data, BedRock-replicated
- fwd_payload_i  in  did_width_p  opaque payload
- out_v_o  out  1  link request valid
- out_ready_i  in  1  link request ready
- out_we_o  out  1  link write
- out_addr_o  out  paddr_width_p  word-aligned byte address
- out_data_o  out  32  write data
- out_mask_o  out  4  byte mask
- out_tag_o  out  1  0=low word, 1=high word
- ret_v_i  in  1  link return valid (always accepted)
- ret_data_i  in  32  load return data
- ret_tag_i  in  1  tag echoed from request
- rev_v_o  out  1  reverse message valid
- rev_ready_and_i  in  1  reverse ready
- rev_store_o  out  1  echoed store flag
- rev_addr_o  out  paddr_width_p  echoed address
- rev_size_o  out  2  echoed size
- rev_data_o  out  64  load data (0 for stores)
- rev_payload_o  out  did_width_p  echoed payload

Behaviour:
- Reset: state=e_ready; fwd_ready_and_o=1; out_v_o=0; rev_v_o=0; return flags clear; data registers 0.
- Reset takes effect in any state; an in-flight transaction is abandoned.
- FSM states: e_ready, e_send_lo, e_send_hi, e_wait, e_reply.
- e_ready:
  - fwd_ready_and_o=1.
  - On fwd_v_i, capture all fwd fields.
  - Low address bits are force-aligned to the size: addr & ~((1<<size)-1).
  - Go to e_send_lo, or to e_send_hi when size<3 and addr[2]=1.
  - A single narrow request uses tag=addr[2].
- Link requests:
  - Registered; out_v_o first asserts the cycle after fwd acceptance.
  - Fields held stable while out_v_o && !out_ready_i.
- Word selection:
  - Low word: addr = {addr[hi:3],3'b000}, data = fwd_data[31:0].
  - High word: addr+4, data = fwd_data[63:32].
- out_mask_o:
  - size 3 or 2: 4'b1111.
  - size 1: 4'b0011 << addr[1:0].
  - size 0: 4'b0001 << addr[1:0].
- Transitions:
  - e_send_lo: handshake goes to e_send_hi if size=3, else e_wait.
  - e_send_hi: handshake goes to e_wait.
- Returns:
  - Accepted in e_send_hi, e_wait, or same cycle as a request handshake.
  - ret_tag_i selects the low or high 32-bit data register and sets its done flag.
  - Halves may return in either order.
  - Returns in e_ready or e_reply are dropped and fire a simulation assertion.
- e_wait goes to e_reply when all expected flags are set (1 flag for size<3, 2 for size=3). The cycle after the final return, rev_v_o=1.
- rev_data_o:
  - Loads, size 3: {hi,lo}.
  - Loads, size<3: the returned word replicated twice.
  - Stores: 0.
- e_reply: held until rev_ready_and_i; on handshake clear flags and go to e_ready. No new fwd accepted in the same cycle.
- Minimum round trip, with out_ready_i=1 and zero-latency returns:
  - Narrow: 3 cycles fwd-accept to rev_v_o.
  - 64-bit: 4 cycles fwd-accept to rev_v_o.

Test Plan:
- Load size 3 @0x8000_0010, returns lo=0x1111_2222 then hi=0x3333_4444 -> two requests (0x8000_0010 tag0, 0x8000_0014 tag1, mask 4'hF); rev_data_o=0x3333_4444_1111_2222, payload echoed.
- Same load, returns hi before lo -> identical rev_data_o; rev_v_o only after second return.
- Store size 0 @0x8000_0006, data 0xAB replicated -> one request, addr 0x8000_0004, tag1, mask 4'b0100, we=1; rev_data_o=0 after its return.
- out_ready_i low 5 cycles during a size-3 store -> out_* fields stable, no duplicate request; fwd_ready_and_o=0 until rev handshake.
- rev_ready_and_i low 3 cycles -> rev_* fields stable, new fwd_v_i not accepted; accepted the cycle after the handshake.
- reset_i asserted in e_wait -> next cycle out_v_o=0, rev_v_o=0, fwd_ready_and_o=1; a late return is dropped with an assertion.
